// File: rtl/pusch_pkg.sv
// Shared types for the PUSCH phase generator: phase word width, phase type and FSM states.
package pusch_pkg;

  localparam int unsigned PHASE_W = 13;

  typedef logic [PHASE_W-1:0] phase_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/pusch_phase_acc.sv
// Registered phase accumulator: load a value, add an increment modulo 2^PHASE_W, or hold.
module pusch_phase_acc
  import pusch_pkg::*;
(
  input  logic   CLK,
  input  logic   RST,
  input  logic   load,
  input  phase_t load_val,
  input  logic   add,
  input  phase_t add_val,
  output phase_t q
);

  phase_t acc_q;

  // Load wins over add; the sum wraps silently at the word width.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc_q <= '0;
    end else if (load) begin
      acc_q <= load_val;
    end else if (add) begin
      acc_q <= acc_q + add_val;
    end
  end

  assign q = acc_q;

endmodule

// File: rtl/pusch_phase_gen.sv
// Per-sample NCO phase generator for one slot of SC-FDMA symbols, with valid/ready output
// handshake and per-symbol phase restart.
module pusch_phase_gen
  import pusch_pkg::*;
#(
  parameter int unsigned SAMP_W = 12,
  parameter int unsigned SYM_W  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  phase_t            fcw,
  input  phase_t            phase_init,
  input  phase_t            sym_step,
  input  logic [SAMP_W-1:0] n_samples,
  input  logic [SYM_W-1:0]  n_symbols,
  output phase_t            phase_out,
  output logic              phase_valid,
  input  logic              phase_ready,
  output logic [SYM_W-1:0]  sym_idx,
  output logic [SAMP_W-1:0] samp_idx,
  output logic              last_samp,
  output logic              last_sym,
  output logic              busy,
  output logic              done
);

  state_e state_q, state_d;

  phase_t            fcw_q;
  phase_t            sym_step_q;
  logic [SAMP_W-1:0] n_samples_q;
  logic [SYM_W-1:0]  n_symbols_q;
  logic [SAMP_W-1:0] samp_idx_q;
  logic [SYM_W-1:0]  sym_idx_q;
  logic              valid_q;

  logic   accept;
  logic   zero_cfg;
  logic   launch;
  logic   xfer;
  logic   end_sym;
  logic   end_slot;
  logic   next_sym;
  phase_t sym_base;
  phase_t phase_load_val;

  assign accept   = (state_q == StIdle) && start;
  assign zero_cfg = (n_samples == '0) || (n_symbols == '0);
  assign launch   = accept && !zero_cfg;
  assign xfer     = valid_q && phase_ready;

  // Flags are gated by valid so they never assert between slots.
  assign last_samp = valid_q && (samp_idx_q == n_samples_q - SAMP_W'(1));
  assign last_sym  = valid_q && (sym_idx_q == n_symbols_q - SYM_W'(1));
  assign end_sym   = last_samp;
  assign end_slot  = last_samp && last_sym;
  assign next_sym  = xfer && end_sym && !end_slot;

  // FSM state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = zero_cfg ? StDone : StRun;
        end
      end
      StRun: begin
        if (xfer && end_slot) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StRun:   busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  // Configuration latch, handshake and sample/symbol counters.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fcw_q       <= '0;
      sym_step_q  <= '0;
      n_samples_q <= '0;
      n_symbols_q <= '0;
      samp_idx_q  <= '0;
      sym_idx_q   <= '0;
      valid_q     <= 1'b0;
    end else if (accept) begin
      fcw_q       <= fcw;
      sym_step_q  <= sym_step;
      n_samples_q <= n_samples;
      n_symbols_q <= n_symbols;
      samp_idx_q  <= '0;
      sym_idx_q   <= '0;
      valid_q     <= launch;
    end else if (xfer) begin
      if (end_slot) begin
        valid_q    <= 1'b0;
        samp_idx_q <= '0;
        sym_idx_q  <= '0;
      end else if (end_sym) begin
        samp_idx_q <= '0;
        sym_idx_q  <= sym_idx_q + SYM_W'(1);
      end else begin
        samp_idx_q <= samp_idx_q + SAMP_W'(1);
      end
    end
  end

  // Start-of-symbol phase: phase_init for symbol 0, advanced by sym_step per symbol.
  pusch_phase_acc u_sym_base (
    .CLK      (CLK),
    .RST      (RST),
    .load     (launch),
    .load_val (phase_init),
    .add      (next_sym),
    .add_val  (sym_step_q),
    .q        (sym_base)
  );

  assign phase_load_val = launch ? phase_init : (sym_base + sym_step_q);

  pusch_phase_acc u_phase (
    .CLK      (CLK),
    .RST      (RST),
    .load     (launch || next_sym),
    .load_val (phase_load_val),
    .add      (xfer && !end_sym),
    .add_val  (fcw_q),
    .q        (phase_out)
  );

  assign phase_valid = valid_q;
  assign sym_idx     = sym_idx_q;
  assign samp_idx    = samp_idx_q;

endmodule

// File: tb/tb_pusch_phase_gen.sv
// Self-checking bench for pusch_phase_gen: directed vector table, reset-mid-slot sequence
// and randomized slots checked against a closed-form phase model.
module tb_pusch_phase_gen;

  localparam int unsigned PW  = 13;
  localparam int unsigned SAW = 12;
  localparam int unsigned SYW = 4;
  localparam int unsigned MODN = 1 << PW;

  logic           CLK = 1'b0;
  logic           RST;
  logic           start;
  logic [PW-1:0]  fcw;
  logic [PW-1:0]  phase_init;
  logic [PW-1:0]  sym_step;
  logic [SAW-1:0] n_samples;
  logic [SYW-1:0] n_symbols;
  logic [PW-1:0]  phase_out;
  logic           phase_valid;
  logic           phase_ready;
  logic [SYW-1:0] sym_idx;
  logic [SAW-1:0] samp_idx;
  logic           last_samp;
  logic           last_sym;
  logic           busy;
  logic           done;

  always #5 CLK = ~CLK;

  pusch_phase_gen dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .fcw         (fcw),
    .phase_init  (phase_init),
    .sym_step    (sym_step),
    .n_samples   (n_samples),
    .n_symbols   (n_symbols),
    .phase_out   (phase_out),
    .phase_valid (phase_valid),
    .phase_ready (phase_ready),
    .sym_idx     (sym_idx),
    .samp_idx    (samp_idx),
    .last_samp   (last_samp),
    .last_sym    (last_sym),
    .busy        (busy),
    .done        (done)
  );

  typedef struct {
    int unsigned phase;
    int unsigned sym;
    int unsigned samp;
    int unsigned ls;
    int unsigned lsy;
  } exp_t;

  typedef struct {
    int unsigned f;
    int unsigned init;
    int unsigned step;
    int unsigned ns;
    int unsigned nsym;
    int          mode;   // 0: ready always, 1: 3-cycle stall mid-symbol, 2: random ready
    int unsigned n_exp;
    int unsigned exp_ph[6];
  } vec_t;

  int   n_pass  = 0;
  int   n_total = 0;
  exp_t        exp_q[$];
  int unsigned obs_q[$];
  vec_t        vecs[7];

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Phase of sample k of symbol s is init + s*step + k*fcw, modulo a full turn.
  task automatic build_model(input int unsigned f, input int unsigned init,
                             input int unsigned step, input int unsigned ns,
                             input int unsigned nsym);
    exp_t e;
    exp_q.delete();
    for (int unsigned s = 0; s < nsym; s++) begin
      for (int unsigned k = 0; k < ns; k++) begin
        e.phase = (init + s * step + k * f) % MODN;
        e.sym   = s;
        e.samp  = k;
        e.ls    = (k == ns - 1) ? 1 : 0;
        e.lsy   = (s == nsym - 1) ? 1 : 0;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic run_slot(input int unsigned f, input int unsigned init, input int unsigned step,
                          input int unsigned ns, input int unsigned nsym, input int mode);
    bit expect_done;
    bit finished;
    int budget;
    build_model(f, init, step, ns, nsym);
    obs_q.delete();
    budget = 4 * exp_q.size() + 20;
    @(posedge CLK); #1;
    fcw         = PW'(f);
    phase_init  = PW'(init);
    sym_step    = PW'(step);
    n_samples   = SAW'(ns);
    n_symbols   = SYW'(nsym);
    start       = 1'b1;
    phase_ready = 1'b1;
    @(posedge CLK); #1;
    start       = 1'b0;
    expect_done = (exp_q.size() == 0);
    finished    = 1'b0;
    for (int cyc = 0; cyc < budget && !finished; cyc++) begin
      case (mode)
        1:       phase_ready = !(cyc >= 2 && cyc < 5);
        2:       phase_ready = ($urandom_range(0, 9) < 7);
        default: phase_ready = 1'b1;
      endcase
      // Mid-slot start with a different config must be ignored.
      if (mode == 2 && !expect_done && $urandom_range(0, 7) == 0) begin
        start      = 1'b1;
        fcw        = PW'($urandom);
        phase_init = PW'($urandom);
        n_samples  = SAW'($urandom_range(1, 9));
        n_symbols  = SYW'($urandom_range(1, 5));
      end else begin
        start = 1'b0;
      end
      @(negedge CLK);
      if (expect_done) begin
        check("done_pulse", 32'(done), 1);
        check("busy_in_done", 32'(busy), 0);
        check("valid_in_done", 32'(phase_valid), 0);
        finished = 1'b1;
      end else begin
        check("no_done_mid_slot", 32'(done), 0);
        check("busy_mid_slot", 32'(busy), 1);
        check("valid_mid_slot", 32'(phase_valid), 1);
        if (!phase_valid) begin
          finished = 1'b1;
        end else begin
          check("phase_out", 32'(phase_out), exp_q[0].phase);
          check("sym_idx", 32'(sym_idx), exp_q[0].sym);
          check("samp_idx", 32'(samp_idx), exp_q[0].samp);
          check("last_samp", 32'(last_samp), exp_q[0].ls);
          check("last_sym", 32'(last_sym), exp_q[0].lsy);
          if (phase_ready) begin
            obs_q.push_back(32'(phase_out));
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) expect_done = 1'b1;
          end
        end
      end
      @(posedge CLK); #1;
    end
    start = 1'b0;
    if (!finished) check("slot_timeout", 0, 1);
    @(negedge CLK);
    check("done_one_cycle", 32'(done), 0);
    check("idle_after_done", 32'(busy), 0);
  endtask

  initial begin
    RST         = 1'b0;
    start       = 1'b0;
    fcw         = '0;
    phase_init  = '0;
    sym_step    = '0;
    n_samples   = '0;
    n_symbols   = '0;
    phase_ready = 1'b0;

    vecs[0] = '{256, 0, 0, 4, 1, 0, 4, '{0, 256, 512, 768, 0, 0}};
    vecs[1] = '{8000, 500, 0, 3, 1, 0, 3, '{500, 308, 116, 0, 0, 0}};
    vecs[2] = '{1, 0, 2048, 2, 3, 0, 6, '{0, 1, 2048, 2049, 4096, 4097}};
    vecs[3] = '{256, 0, 0, 4, 1, 1, 4, '{0, 256, 512, 768, 0, 0}};
    vecs[4] = '{256, 0, 0, 4, 0, 0, 0, '{0, 0, 0, 0, 0, 0}};
    vecs[5] = '{256, 0, 0, 0, 2, 0, 0, '{0, 0, 0, 0, 0, 0}};
    vecs[6] = '{0, 100, 1000, 3, 2, 2, 6, '{100, 100, 100, 1100, 1100, 1100}};

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_phase_out", 32'(phase_out), 0);
    check("rst_valid", 32'(phase_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_sym_idx", 32'(sym_idx), 0);
    check("rst_samp_idx", 32'(samp_idx), 0);
    RST = 1'b1;

    for (int v = 0; v < 7; v++) begin
      run_slot(vecs[v].f, vecs[v].init, vecs[v].step, vecs[v].ns, vecs[v].nsym, vecs[v].mode);
      check($sformatf("vec%0d_count", v), obs_q.size(), vecs[v].n_exp);
      for (int i = 0; i < obs_q.size() && i < vecs[v].n_exp; i++)
        check($sformatf("vec%0d_phase%0d", v, i), obs_q[i], vecs[v].exp_ph[i]);
    end

    // Reset in the middle of symbol 1.
    @(posedge CLK); #1;
    fcw = 13'd1; phase_init = '0; sym_step = 13'd2048;
    n_samples = 12'd2; n_symbols = 4'd3; phase_ready = 1'b1; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (sym_idx == 4'd1) break;
    end
    check("rst_reached_sym1", 32'(sym_idx), 1);
    RST = 1'b0;
    #1;
    check("midrst_valid", 32'(phase_valid), 0);
    check("midrst_phase_out", 32'(phase_out), 0);
    check("midrst_sym_idx", 32'(sym_idx), 0);
    check("midrst_samp_idx", 32'(samp_idx), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("midrst_no_done", 32'(done), 0);
      check("midrst_no_valid", 32'(phase_valid), 0);
    end
    run_slot(1, 0, 2048, 2, 3, 0);
    check("post_rst_count", obs_q.size(), 6);

    for (int r = 0; r < 20; r++) begin
      run_slot($urandom % MODN, $urandom % MODN, $urandom % MODN,
               $urandom_range(0, 6), $urandom_range(0, 4), 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
